// File: rtl/uart_pkg.sv
// Shared types and constants for the buffered word UART transmitter.
package uart_pkg;

   typedef enum logic [2:0] {
      StIdle   = 3'd0,
      StStart  = 3'd1,
      StData   = 3'd2,
      StParity = 3'd3,
      StStop   = 3'd4,
      StDone   = 3'd5
   } frame_state_e;

   localparam logic [31:0] TX_ADDR_DEFAULT = 32'hFFFF_FFFF;
   localparam int unsigned BYTE_W          = 8;

endpackage

// File: rtl/uart_word_fifo.sv
// Synchronous 32-bit word FIFO with registered full/empty flags.
module uart_word_fifo #(
   parameter int unsigned DEPTH = 4
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        i_push,
   input  logic        i_pop,
   input  logic [31:0] i_wdata,
   output logic [31:0] o_rdata,
   output logic        o_full,
   output logic        o_empty
);

   localparam int unsigned PTR_W = $clog2(DEPTH);
   localparam logic [PTR_W:0] FULL_CNT = (PTR_W + 1)'(DEPTH);

   logic [31:0]      r_mem [DEPTH];
   logic [PTR_W-1:0] r_wr_ptr;
   logic [PTR_W-1:0] r_rd_ptr;
   logic [PTR_W:0]   r_count;
   logic             r_full;
   logic             r_empty;

   logic             w_push;
   logic             w_pop;
   logic [PTR_W:0]   w_count_d;

   assign w_push = i_push && !r_full;
   assign w_pop  = i_pop && !r_empty;

   always_comb begin
      w_count_d = r_count;
      case ({w_push, w_pop})
         2'b10:   w_count_d = r_count + 1'b1;
         2'b01:   w_count_d = r_count - 1'b1;
         default: w_count_d = r_count;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
         r_full   <= 1'b0;
         r_empty  <= 1'b1;
      end else begin
         if (w_push) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
         if (w_pop)  r_rd_ptr <= r_rd_ptr + PTR_W'(1);
         r_count <= w_count_d;
         r_full  <= (w_count_d == FULL_CNT);
         r_empty <= (w_count_d == '0);
      end
   end

   // Storage needs no reset; the pointers define what is valid.
   always_ff @(posedge clk) begin
      if (w_push) r_mem[r_wr_ptr] <= i_wdata;
   end

   assign o_rdata = r_mem[r_rd_ptr];
   assign o_full  = r_full;
   assign o_empty = r_empty;

endmodule

// File: rtl/uart_word_tx.sv
// Memory-mapped word UART transmitter: bus decode, word FIFO, frame engine, sticky overflow.
// Optional parity bit per frame when UART_TX_PARITY_EN is defined.
module uart_word_tx
   import uart_pkg::*;
#(
   parameter int unsigned CLKS_PER_BIT = 87,
   parameter int unsigned FIFO_DEPTH   = 4,
   parameter int unsigned WORD_BYTES   = 4,
   parameter int unsigned STOP_BITS    = 1,
   parameter logic [31:0] TX_ADDR      = TX_ADDR_DEFAULT,
   parameter int unsigned PARITY_ODD   = 0
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        we,
   input  logic [31:0] address,
   input  logic [31:0] dataIn,
   output logic        serial,
   output logic        tx_active,
   output logic        tx_done,
   output logic        fifo_full,
   output logic        fifo_empty,
   output logic        overflow
);

   localparam int unsigned CNT_W     = $clog2(CLKS_PER_BIT);
   localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(CLKS_PER_BIT - 1);
   localparam logic [2:0] STOP_LAST  = 3'(STOP_BITS - 1);
   localparam logic [1:0] BYTE_LAST  = 2'(WORD_BYTES - 1);

   if (CLKS_PER_BIT < 2 || FIFO_DEPTH < 2 || FIFO_DEPTH > 64 ||
       (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0 || WORD_BYTES < 1 || WORD_BYTES > 4 ||
       STOP_BITS < 1 || STOP_BITS > 2 || PARITY_ODD > 1) begin : g_bad_params
      $error("uart_word_tx: illegal parameter value");
   end

`ifdef UART_TX_PARITY_EN
   localparam logic PARITY_INV = PARITY_ODD[0];
`endif

   frame_state_e     r_state, w_state_d;
   logic [CNT_W-1:0] r_cnt, w_cnt_d;
   logic [2:0]       r_bit_idx, w_bit_idx_d;
   logic [1:0]       r_byte_idx, w_byte_idx_d;
   logic [31:0]      r_shift, w_shift_d;
   logic             r_serial, w_serial_d;
   logic             r_active, w_active_d;
   logic             r_done, w_done_d;
   logic             r_overflow;

   logic             w_addr_hit;
   logic             w_push;
   logic             w_pop;
   logic             w_tick;
   logic [31:0]      w_rdata;
   logic             w_fifo_full;
   logic             w_fifo_empty;
   logic [BYTE_W-1:0] w_cur_byte;

   assign w_addr_hit = we && (address == TX_ADDR);
   assign w_push     = w_addr_hit && !w_fifo_full;
   assign w_tick     = (r_cnt == CNT_MAX);
   assign w_cur_byte = r_shift[BYTE_W-1:0];

   uart_word_fifo #(
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk     (clk),
      .rst_n   (rst_n),
      .i_push  (w_push),
      .i_pop   (w_pop),
      .i_wdata (dataIn),
      .o_rdata (w_rdata),
      .o_full  (w_fifo_full),
      .o_empty (w_fifo_empty)
   );

   // Outputs are registered from the next-state values so serial tracks the state it enters.
   always_comb begin
      w_state_d    = r_state;
      w_cnt_d      = w_tick ? '0 : r_cnt + CNT_W'(1);
      w_bit_idx_d  = r_bit_idx;
      w_byte_idx_d = r_byte_idx;
      w_shift_d    = r_shift;
      w_serial_d   = r_serial;
      w_active_d   = r_active;
      w_done_d     = 1'b0;
      w_pop        = 1'b0;
      case (r_state)
         StIdle: begin
            w_cnt_d    = '0;
            w_serial_d = 1'b1;
            w_active_d = 1'b0;
            if (!w_fifo_empty) begin
               w_pop        = 1'b1;
               w_shift_d    = w_rdata;
               w_byte_idx_d = '0;
               w_state_d    = StStart;
               w_serial_d   = 1'b0;
               w_active_d   = 1'b1;
            end
         end
         StStart: begin
            if (w_tick) begin
               w_state_d   = StData;
               w_bit_idx_d = '0;
               w_serial_d  = w_cur_byte[0];
            end
         end
         StData: begin
            if (w_tick) begin
               if (r_bit_idx == 3'd7) begin
                  w_bit_idx_d = '0;
`ifdef UART_TX_PARITY_EN
                  w_state_d   = StParity;
                  w_serial_d  = (^w_cur_byte) ^ PARITY_INV;
`else
                  w_state_d   = StStop;
                  w_serial_d  = 1'b1;
`endif
               end else begin
                  w_bit_idx_d = r_bit_idx + 3'd1;
                  w_serial_d  = w_cur_byte[r_bit_idx + 3'd1];
               end
            end
         end
`ifdef UART_TX_PARITY_EN
         StParity: begin
            if (w_tick) begin
               w_state_d   = StStop;
               w_bit_idx_d = '0;
               w_serial_d  = 1'b1;
            end
         end
`endif
         StStop: begin
            if (w_tick) begin
               if (r_bit_idx != STOP_LAST) begin
                  w_bit_idx_d = r_bit_idx + 3'd1;
               end else if (r_byte_idx != BYTE_LAST) begin
                  w_byte_idx_d = r_byte_idx + 2'd1;
                  w_shift_d    = r_shift >> BYTE_W;
                  w_state_d    = StStart;
                  w_serial_d   = 1'b0;
               end else begin
                  w_state_d  = StDone;
                  w_serial_d = 1'b1;
                  w_active_d = 1'b0;
                  w_done_d   = 1'b1;
               end
            end
         end
         StDone: begin
            w_cnt_d   = '0;
            w_state_d = StIdle;
         end
         default: begin
            w_cnt_d    = '0;
            w_state_d  = StIdle;
            w_serial_d = 1'b1;
            w_active_d = 1'b0;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state    <= StIdle;
         r_cnt      <= '0;
         r_bit_idx  <= '0;
         r_byte_idx <= '0;
         r_shift    <= '0;
         r_serial   <= 1'b1;
         r_active   <= 1'b0;
         r_done     <= 1'b0;
         r_overflow <= 1'b0;
      end else begin
         r_state    <= w_state_d;
         r_cnt      <= w_cnt_d;
         r_bit_idx  <= w_bit_idx_d;
         r_byte_idx <= w_byte_idx_d;
         r_shift    <= w_shift_d;
         r_serial   <= w_serial_d;
         r_active   <= w_active_d;
         r_done     <= w_done_d;
         r_overflow <= r_overflow | (w_addr_hit & w_fifo_full);
      end
   end

   assign serial     = r_serial;
   assign tx_active  = r_active;
   assign tx_done    = r_done;
   assign fifo_full  = w_fifo_full;
   assign fifo_empty = w_fifo_empty;
   assign overflow   = r_overflow;

endmodule

// File: tb/tb_uart_word_tx.sv
// Self-checking bench for uart_word_tx; parity instances are added when UART_TX_PARITY_EN is set.
module tb_uart_word_tx;

   localparam int CPB = 4;
   localparam logic [31:0] TXA = 32'hFFFF_FFFF;
`ifdef UART_TX_PARITY_EN
   localparam int NDUT = 4;
`else
   localparam int NDUT = 2;
`endif

   logic        clk = 1'b0;
   logic        rst_n;
   logic [31:0] address;
   logic [31:0] data_in;
   logic        we    [NDUT];
   logic        ser   [NDUT];
   logic        act   [NDUT];
   logic        done  [NDUT];
   logic        full  [NDUT];
   logic        empty [NDUT];
   logic        ovf   [NDUT];

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   uart_word_tx #(.CLKS_PER_BIT(CPB)) u_dut0 (
      .clk(clk), .rst_n(rst_n), .we(we[0]), .address(address), .dataIn(data_in),
      .serial(ser[0]), .tx_active(act[0]), .tx_done(done[0]), .fifo_full(full[0]),
      .fifo_empty(empty[0]), .overflow(ovf[0])
   );

   uart_word_tx #(.CLKS_PER_BIT(CPB), .WORD_BYTES(1), .STOP_BITS(2)) u_dut1 (
      .clk(clk), .rst_n(rst_n), .we(we[1]), .address(address), .dataIn(data_in),
      .serial(ser[1]), .tx_active(act[1]), .tx_done(done[1]), .fifo_full(full[1]),
      .fifo_empty(empty[1]), .overflow(ovf[1])
   );

`ifdef UART_TX_PARITY_EN
   uart_word_tx #(.CLKS_PER_BIT(CPB), .WORD_BYTES(1), .PARITY_ODD(0)) u_dut2 (
      .clk(clk), .rst_n(rst_n), .we(we[2]), .address(address), .dataIn(data_in),
      .serial(ser[2]), .tx_active(act[2]), .tx_done(done[2]), .fifo_full(full[2]),
      .fifo_empty(empty[2]), .overflow(ovf[2])
   );

   uart_word_tx #(.CLKS_PER_BIT(CPB), .WORD_BYTES(1), .PARITY_ODD(1)) u_dut3 (
      .clk(clk), .rst_n(rst_n), .we(we[3]), .address(address), .dataIn(data_in),
      .serial(ser[3]), .tx_active(act[3]), .tx_done(done[3]), .fifo_full(full[3]),
      .fifo_empty(empty[3]), .overflow(ovf[3])
   );
`endif

   task automatic bus_write(input int k, input logic [31:0] a, input logic [31:0] d);
      @(negedge clk);
      we[k]   = 1'b1;
      address = a;
      data_in = d;
      @(negedge clk);
      we[k] = 1'b0;
   endtask

   // Reference model: the expected line is a list of bit values, each held CPB cycles.
   task automatic check_word(input int k, input logic [31:0] w, input int nb, input int stops,
                             input bit par, input bit odd, output int waited);
      bit         q[$];
      logic [7:0] b;
      int         bad = 0;
      int         first_bad = -1;
      int         act_bad = 0;
      for (int i = 0; i < nb; i++) begin
         b = w[8*i +: 8];
         q.push_back(1'b0);
         for (int j = 0; j < 8; j++) q.push_back(b[j]);
         if (par) q.push_back((^b) ^ odd);
         for (int s = 0; s < stops; s++) q.push_back(1'b1);
      end
      waited = 0;
      while (ser[k] !== 1'b0 && waited < 2000) begin
         @(negedge clk);
         waited++;
      end
      checks++;
      if (ser[k] !== 1'b0) begin
         errors++;
         $display("FAIL start_timeout dut%0d: serial=%b after %0d cycles, required 0",
                  k, ser[k], waited);
         return;
      end
      foreach (q[i]) begin
         for (int c = 0; c < CPB; c++) begin
            if (ser[k] !== q[i]) begin
               bad++;
               if (first_bad < 0) first_bad = i * CPB + c;
            end
            if (act[k] !== 1'b1 || done[k] !== 1'b0) act_bad++;
            @(negedge clk);
         end
      end
      checks++;
      if (bad != 0) begin
         errors++;
         $display("FAIL frame dut%0d word %h: %0d wrong line cycles (first at %0d), required 0",
                  k, w, bad, first_bad);
      end
      checks++;
      if (act_bad != 0) begin
         errors++;
         $display("FAIL active_in_frame dut%0d: %0d cycles with tx_active!=1 or tx_done!=0, required 0",
                  k, act_bad);
      end
      checks++;
      if (done[k] !== 1'b1 || act[k] !== 1'b0 || ser[k] !== 1'b1) begin
         errors++;
         $display("FAIL done_pulse dut%0d: tx_done=%b tx_active=%b serial=%b, required 1 0 1",
                  k, done[k], act[k], ser[k]);
      end
      @(negedge clk);
      checks++;
      if (done[k] !== 1'b0 || ser[k] !== 1'b1) begin
         errors++;
         $display("FAIL done_single dut%0d: tx_done=%b serial=%b, required 0 1", k, done[k], ser[k]);
      end
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      repeat (3) @(negedge clk);
      checks++; if (ser[0] !== 1'b1)   begin errors++; $display("FAIL rst_serial: got %b, required 1", ser[0]); end
      checks++; if (act[0] !== 1'b0)   begin errors++; $display("FAIL rst_active: got %b, required 0", act[0]); end
      checks++; if (done[0] !== 1'b0)  begin errors++; $display("FAIL rst_done: got %b, required 0", done[0]); end
      checks++; if (full[0] !== 1'b0)  begin errors++; $display("FAIL rst_full: got %b, required 0", full[0]); end
      checks++; if (empty[0] !== 1'b1) begin errors++; $display("FAIL rst_empty: got %b, required 1", empty[0]); end
      checks++; if (ovf[0] !== 1'b0)   begin errors++; $display("FAIL rst_overflow: got %b, required 0", ovf[0]); end
      rst_n = 1'b1;
      @(negedge clk);
   endtask

   task automatic test_single_word();
      logic [31:0] w;
      int          waited;
      for (int n = 0; n < 4; n++) begin
         w = (n == 0) ? 32'h4433_2211 : $urandom;
         bus_write(0, TXA, w);
         checks++;
         if (empty[0] !== 1'b0 || ser[0] !== 1'b1) begin
            errors++;
            $display("FAIL accept word %h: fifo_empty=%b serial=%b, required 0 1", w, empty[0], ser[0]);
         end
         check_word(0, w, 4, 1, 1'b0, 1'b0, waited);
         checks++;
         if (waited != 1) begin
            errors++;
            $display("FAIL pop_latency word %h: %0d cycles, required 1", w, waited);
         end
         checks++;
         if (empty[0] !== 1'b1) begin
            errors++;
            $display("FAIL empty_after_word: got %b, required 1", empty[0]);
         end
      end
   endtask

   task automatic test_bad_address();
      logic [31:0] a;
      int          bad = 0;
      a = $urandom;
      if (a == TXA) a = 32'h0;
      bus_write(0, 32'h0000_1000, 32'h4433_2211);
      bus_write(0, a, $urandom);
      @(negedge clk);
      address = TXA;
      data_in = $urandom;
      for (int i = 0; i < 30; i++) begin
         if (empty[0] !== 1'b1 || ser[0] !== 1'b1 || ovf[0] !== 1'b0) bad++;
         @(negedge clk);
      end
      checks++;
      if (bad != 0) begin
         errors++;
         $display("FAIL bad_address: %0d cycles with a push or line activity, required 0", bad);
      end
   endtask

   task automatic test_back_to_back();
      logic [31:0] d[6];
      int          bad = 0;
      foreach (d[i]) d[i] = $urandom;
      fork
         begin
            for (int i = 0; i < 6; i++) begin
               @(negedge clk);
               if (i == 5) begin
                  checks++;
                  if (full[0] !== 1'b1) begin
                     errors++;
                     $display("FAIL full_before_6th: got %b, required 1", full[0]);
                  end
               end
               we[0]   = 1'b1;
               address = TXA;
               data_in = d[i];
            end
            @(negedge clk);
            we[0] = 1'b0;
            checks++;
            if (ovf[0] !== 1'b1) begin
               errors++;
               $display("FAIL overflow_set: got %b, required 1", ovf[0]);
            end
         end
         begin
            int waited;
            for (int i = 0; i < 5; i++) begin
               check_word(0, d[i], 4, 1, 1'b0, 1'b0, waited);
               if (i > 0) begin
                  checks++;
                  if (waited != 1) begin
                     errors++;
                     $display("FAIL gap word %0d: start %0d cycles after idle, required 1", i, waited);
                  end
               end
            end
         end
      join
      for (int i = 0; i < 60; i++) begin
         if (ser[0] !== 1'b1 || empty[0] !== 1'b1) bad++;
         @(negedge clk);
      end
      checks++;
      if (bad != 0) begin
         errors++;
         $display("FAIL dropped_word_sent: %0d active cycles after 5 words, required 0", bad);
      end
      checks++;
      if (ovf[0] !== 1'b1) begin
         errors++;
         $display("FAIL overflow_sticky: got %b, required 1", ovf[0]);
      end
   endtask

   task automatic test_word_bytes1();
      logic [31:0] w;
      int          waited;
      int          bad;
      for (int n = 0; n < 3; n++) begin
         w   = (n == 0) ? 32'hFFFF_FFA5 : $urandom;
         bad = 0;
         bus_write(1, TXA, w);
         check_word(1, w, 1, 2, 1'b0, 1'b0, waited);
         checks++;
         if (waited != 1) begin
            errors++;
            $display("FAIL wb1_pop_latency: %0d cycles, required 1", waited);
         end
         for (int i = 0; i < 20; i++) begin
            if (ser[1] !== 1'b1 || act[1] !== 1'b0) bad++;
            @(negedge clk);
         end
         checks++;
         if (bad != 0) begin
            errors++;
            $display("FAIL wb1_upper_bytes word %h: %0d active cycles, required 0", w, bad);
         end
      end
   endtask

`ifdef UART_TX_PARITY_EN
   task automatic test_parity();
      logic [31:0] w;
      int          waited;
      for (int k = 2; k < 4; k++) begin
         for (int n = 0; n < 3; n++) begin
            w = (n == 0) ? {$urandom_range(255, 0), 24'h0, 8'h07} >> 8 : $urandom;
            if (n == 0) w = {24'hABCDEF, 8'h07};
            bus_write(k, TXA, w);
            check_word(k, w, 1, 1, 1'b1, (k == 3), waited);
         end
      end
   endtask
`endif

   task automatic test_reset_midframe();
      logic [31:0] d0;
      int          bad = 0;
      d0 = $urandom;
      bus_write(0, TXA, d0);
      @(negedge clk);
      bus_write(0, TXA, $urandom);
      repeat (2 * 40 + 4 + 10 - 3) @(negedge clk);
      checks++;
      if (act[0] !== 1'b1 || empty[0] !== 1'b0) begin
         errors++;
         $display("FAIL midframe_setup: tx_active=%b fifo_empty=%b, required 1 0", act[0], empty[0]);
      end
      #2 rst_n = 1'b0;
      #1;
      checks++;
      if (ser[0] !== 1'b1 || act[0] !== 1'b0 || empty[0] !== 1'b1 || ovf[0] !== 1'b0) begin
         errors++;
         $display("FAIL async_reset: serial=%b active=%b empty=%b overflow=%b, required 1 0 1 0",
                  ser[0], act[0], empty[0], ovf[0]);
      end
      @(negedge clk);
      rst_n = 1'b1;
      for (int i = 0; i < 100; i++) begin
         @(negedge clk);
         if (ser[0] !== 1'b1 || act[0] !== 1'b0 || empty[0] !== 1'b1) bad++;
      end
      checks++;
      if (bad != 0) begin
         errors++;
         $display("FAIL after_reset_idle: %0d active cycles, required 0", bad);
      end
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      for (int i = 0; i < NDUT; i++) we[i] = 1'b0;
      address = '0;
      data_in = '0;
      test_reset();
      test_single_word();
      test_bad_address();
      test_back_to_back();
      test_word_bytes1();
`ifdef UART_TX_PARITY_EN
      test_parity();
`endif
      test_reset_midframe();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/uart_word_tx.md
# uart_word_tx

Memory-mapped UART transmitter for the SoC bus. A CPU store of a 32-bit word to the transmit address queues the word in an internal FIFO. A frame engine then sends the word as `WORD_BYTES` consecutive 8N1/8P1 frames, least-significant byte first. It is the buffered, parametrised successor of the single-word serializer and sits on the data bus beside memory, driving the board TX pin.

## Interface
Parameters:
- `CLKS_PER_BIT`, 87: clk cycles per bit, ≥ 2; equals f_clk / baud.
- `FIFO_DEPTH`, 4: word entries; power of two, 2..64.
- `WORD_BYTES`, 4: bytes sent per queued word, 1..4, starting at byte 0.
- `STOP_BITS`, 1: 1 or 2.
- `TX_ADDR`, 32'hFFFF_FFFF: bus address that accepts writes.
- `PARITY_ODD`, 0: 0 selects even parity, 1 selects odd. Only meaningful with the parity macro.

Ports:
- `clk` in 1: single clock.
- `rst_n` in 1: reset, asynchronous assert, active-low.
- `we` in 1: bus write strobe.
- `address` in 32: bus address.
- `dataIn` in 32: bus write data.
- `serial` out 1: UART TX line; idle high.
- `tx_active` out 1: high from pop through the last stop bit of the word.
- `tx_done` out 1: one-cycle pulse after a word's last stop bit.
- `fifo_full` out 1: FIFO holds `FIFO_DEPTH` words.
- `fifo_empty` out 1: FIFO holds 0 words.
- `overflow` out 1: sticky; set by a write that was dropped because the FIFO was full.

## Operation
- Push condition: `we && address == TX_ADDR && !fifo_full`.
- The same write with `fifo_full` high is dropped and sets `overflow`. `overflow` clears only on reset.
- Push and pop in the same cycle are legal when the FIFO is not full. The count is unchanged. A write when full is dropped even if a pop happens in that cycle.
- Frame engine states:
  - IDLE: `serial`=1. If the FIFO is not empty, pop a word into the shift register, clear the byte index, go to START.
  - START: `serial`=0 for `CLKS_PER_BIT` cycles, then DATA.
  - DATA: bits 0..7 of the current byte, LSB first, each held `CLKS_PER_BIT` cycles. Then PARITY (macro on) or STOP.
  - PARITY: XOR of the 8 data bits, inverted when `PARITY_ODD`=1. Held 1 bit time, then STOP.
  - STOP: `serial`=1 for `STOP_BITS` bit times. If byte index < `WORD_BYTES`-1, increment the index, shift the word right by 8, go to START with no idle gap. Otherwise go to DONE.
  - DONE: one cycle. `tx_done`=1, `tx_active`=0, go to IDLE. The next pop can occur in the IDLE cycle that follows.
- The bit counter is `$clog2(CLKS_PER_BIT)` bits wide and wraps to 0 at `CLKS_PER_BIT`-1. The bit index is 3 bits; the byte index is 2 bits.
- Upper bytes beyond `WORD_BYTES` are ignored.
- Reset asserted mid-frame:
  - FIFO empties and state returns to IDLE immediately.
  - `serial` goes high. The partial frame is abandoned with no stop bit guarantee.
- Reset values: `serial`=1, `tx_active`=0, `tx_done`=0, `fifo_full`=0, `fifo_empty`=1, `overflow`=0.

## Timing
- All outputs are registered.
- Write accepted at edge k: `fifo_empty` falls after edge k.
- If the engine is idle, the pop happens at edge k+1. `serial` falls and `tx_active` rises after edge k+1.
- Word duration from the start-bit fall to `tx_done`: `WORD_BYTES`·(10 + P + `STOP_BITS` − 1)·`CLKS_PER_BIT` cycles, where P=1 with parity and P=0 without. `tx_done` asserts in the cycle immediately after.
- Minimum gap between words: 2 idle-high cycles (DONE, then IDLE).

## Configuration
- `UART_TX_PARITY_EN` defined: the PARITY state exists and each frame is 12 bits with 2 stop bits (11 with 1).
- `UART_TX_PARITY_EN` undefined: the PARITY state and its logic are absent, and `PARITY_ODD` has no effect.

## Structure
- Package `uart_pkg` holds:
  - the frame state encoding (IDLE, START, DATA, PARITY, STOP, DONE; 3 bits);
  - the default `TX_ADDR`;
  - the 8-bit byte-width constant.
- Sub-module `uart_word_fifo`: synchronous FIFO, 32-bit wide, `FIFO_DEPTH` deep, with push/pop and full/empty flags. Count is `$clog2(FIFO_DEPTH)`+1 bits.
- The top level holds the bus decode, the frame engine and `overflow`.

## Test plan
All scenarios use `CLKS_PER_BIT`=4.
- Write 32'h44332211 to `TX_ADDR` -> line carries bytes 11, 22, 33, 44 (LSB first), each with start and stop bits; one `tx_done` pulse exactly 160 cycles after the start-bit fall.
- Write the same data to address 32'h0000_1000 -> no push; `fifo_empty` stays 1 and `serial` stays 1.
- 5 back-to-back writes with `FIFO_DEPTH`=4 -> the first is popped and 4 are queued; a 6th write sets `overflow` and is dropped. Exactly 5 words are transmitted, in order.
- With `UART_TX_PARITY_EN`, `PARITY_ODD`=0, send byte 8'h07 -> parity bit 1. With `PARITY_ODD`=1 -> parity bit 0.
- `WORD_BYTES`=1, `STOP_BITS`=2, write 32'hFFFFFFA5 -> single frame A5 with 8 high stop cycles; upper bytes are not sent.
- Assert `rst_n` low during byte 2's DATA state -> `serial`=1 and `tx_active`=0 immediately; FIFO empty; nothing is sent after release.
